wb_mailbox_responder: RTL and testbench
=======================================

Name: wb_mailbox_responder

Overview:
- Wishbone classic slave responder for the management SoC's wbs_* port into the user project.
- Provides a bidirectional mailbox between the management core and the user core.
- Management-to-core (M2C) FIFO: filled by Wishbone writes, drained by the core through a valid/ready port.
- Core-to-management (C2M) FIFO: filled by the core, drained by Wishbone reads. Sits in user_project_wrapper beside the core.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; decode on adr[31:4] == BASE_ADDR[31:4].
- DEPTH, 4, entries per FIFO; power of two, range 2..128.

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- m2c_data  out  32  M2C FIFO head.
- m2c_valid  out  1  M2C FIFO not empty.
- m2c_ready  in  1  core pops M2C head when valid&ready.
- c2m_data  in  32  core push data.
- c2m_valid  in  1  core push request.
- c2m_ready  out  1  C2M FIFO not full.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset values (asynchronous, rst_n low): wbs_ack_o=0, wbs_dat_o=0, irq=0, both FIFOs empty, counts 0, sticky flags 0, CTRL 0. Consequently m2c_valid=0 and c2m_ready=1.
- Request condition: req = cyc & stb & addr match & !wbs_ack_o.
- On the req edge, wbs_ack_o is set for exactly one cycle, and all side effects occur at that same edge.
- Read data is registered together with the ack.
- A strobe held high gets one ack per two cycles.
- Addresses that do not match are never acked.
- Register map (offset = adr[3:2]):
  - 0 DATA. Write with sel[0]=1: push wbs_dat_i into M2C. If M2C is full: drop the data, set OVF, still ack. Write with sel==0: no push. Read: return the C2M head and pop it. If C2M is empty: return 0, set UDF, still ack.
  - 1 STATUS. Bit0 C2M not empty; bit1 M2C full; bit2 M2C empty; bit3 C2M full; bit4 OVF (sticky); bit5 UDF (sticky); [15:8] C2M count; [23:16] M2C count; other bits 0. Writing 1 to bits 4/5 clears them (W1C, lane 0 only). The count field is wide enough for count==DEPTH; DEPTH=128 fits in 8 bits.
  - 2 CTRL. Bit0 RXIE, bit1 TXIE, bit2 ERRIE; written when sel[0]=1. Read returns the value; unused bits 0.
  - 3 reserved. Reads 0, writes ignored, still acked.
- FIFOs: circular buffers with read/write pointers of log2(DEPTH) bits plus a count. Pointers wrap modulo DEPTH.
- Core push into C2M occurs when c2m_valid & c2m_ready.
- Simultaneous push and pop on the same FIFO in one cycle: both take effect, count unchanged. This applies to C2M core push + Wishbone DATA read, and to M2C Wishbone DATA write + core pop.
- A push while full is blocked: on the core side by c2m_ready=0, on the bus side by the OVF rule. This holds even if a pop occurs in the same cycle, because fullness is judged on the pre-edge count.
- m2c_data is the combinational head entry. It is stable while m2c_valid=1 and no pop occurs.
- irq is registered from (RXIE & C2M not empty) | (TXIE & M2C empty) | (ERRIE & (OVF|UDF)), with one cycle of latency.
- Reset mid-transaction drops ack immediately and flushes both FIFOs. The master must restart the cycle.

Optional Feature:
- MBOX_IRQ_EN defined: CTRL register and irq generation as above.
- MBOX_IRQ_EN undefined:
  - irq is tied to 0.
  - CTRL reads 0 and writes are ignored, but still acked.
  - No CTRL flops are implemented.

Test Plan:
- Reset, then read STATUS (adr BASE+4) -> ack after 1 cycle; data 0x0000_0004 (M2C empty). irq=0 and c2m_ready=1 after reset.
- Write 0xDEAD_BEEF, then 0x1234_5678, to BASE+0 with sel=4'hF and m2c_ready=0 -> m2c_valid=1, m2c_data=0xDEADBEEF, STATUS[23:16]=2. Then pulse m2c_ready for one cycle -> m2c_data=0x12345678.
- Core pushes 5 words with DEPTH=4 -> c2m_ready=0 after 4 pushes. Wishbone reads return words 1..4 in order. A 5th read returns 0 and sets STATUS bit5; W1C write 0x20 to STATUS clears it.
- Write 5 words to DATA with the core not popping -> 5th write acked but dropped, OVF=1. Four entries remain, then pointer wrap-around verified by 3 more push/pop rounds.
- With C2M holding 1 entry, core push and Wishbone DATA read on the same edge -> count stays 1, and the read returns the older word.
- With MBOX_IRQ_EN, write CTRL=1, then the core pushes one word -> irq=1 on the second edge after the push; a DATA read drains C2M and irq falls. Without MBOX_IRQ_EN, irq stays 0 and CTRL reads 0.

Source files
------------

// File: rtl/wb_mailbox_responder.sv
// Wishbone classic mailbox: a bus-filled M2C FIFO drained by the core, and a core-filled C2M FIFO drained by bus reads.
// Optional CTRL register and irq output are built only when MBOX_IRQ_EN is defined.
module wb_mailbox_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] m2c_data,
  output logic        m2c_valid,
  input  logic        m2c_ready,
  input  logic [31:0] c2m_data,
  input  logic        c2m_valid,
  output logic        c2m_ready,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  logic          req;
  logic [1:0]    off;
  logic          wr_lane0;

  logic [31:0]   m2c_mem [DEPTH];
  logic [AW-1:0] m2c_wptr, m2c_rptr;
  logic [CW-1:0] m2c_count;
  logic          m2c_full, m2c_empty, m2c_push, m2c_pop;

  logic [31:0]   c2m_mem [DEPTH];
  logic [AW-1:0] c2m_wptr, c2m_rptr;
  logic [CW-1:0] c2m_count;
  logic          c2m_full, c2m_empty, c2m_push, c2m_pop;

  logic          ovf, udf;
  logic          ovf_set, udf_set, ovf_clr, udf_clr;
  logic [7:0]    m2c_cnt8, c2m_cnt8;
  logic [31:0]   status_word, ctrl_word, rd_data;
  logic          sig_unused;

  assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign off      = wbs_adr_i[3:2];
  assign wr_lane0 = req & wbs_we_i & wbs_sel_i[0];

  assign m2c_full  = (m2c_count == FULL_CNT);
  assign m2c_empty = (m2c_count == '0);
  assign c2m_full  = (c2m_count == FULL_CNT);
  assign c2m_empty = (c2m_count == '0);

  // Fullness and emptiness are judged on the pre-edge count, so a same-cycle pop never frees room for a push.
  assign m2c_push = wr_lane0 & (off == OFF_DATA) & ~m2c_full;
  assign ovf_set  = wr_lane0 & (off == OFF_DATA) & m2c_full;
  assign m2c_pop  = m2c_valid & m2c_ready;

  assign c2m_push = c2m_valid & c2m_ready;
  assign c2m_pop  = req & ~wbs_we_i & (off == OFF_DATA) & ~c2m_empty;
  assign udf_set  = req & ~wbs_we_i & (off == OFF_DATA) & c2m_empty;

  assign ovf_clr = wr_lane0 & (off == OFF_STATUS) & wbs_dat_i[4];
  assign udf_clr = wr_lane0 & (off == OFF_STATUS) & wbs_dat_i[5];

  assign m2c_valid = ~m2c_empty;
  assign m2c_data  = m2c_mem[m2c_rptr];
  assign c2m_ready = ~c2m_full;

  always_ff @(posedge wb_clk_i) begin
    if (m2c_push) m2c_mem[m2c_wptr] <= wbs_dat_i;
    if (c2m_push) c2m_mem[c2m_wptr] <= c2m_data;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m2c_wptr  <= '0;
      m2c_rptr  <= '0;
      m2c_count <= '0;
    end else begin
      if (m2c_push) m2c_wptr <= m2c_wptr + 1'b1;
      if (m2c_pop)  m2c_rptr <= m2c_rptr + 1'b1;
      if (m2c_push && !m2c_pop)      m2c_count <= m2c_count + 1'b1;
      else if (!m2c_push && m2c_pop) m2c_count <= m2c_count - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      c2m_wptr  <= '0;
      c2m_rptr  <= '0;
      c2m_count <= '0;
    end else begin
      if (c2m_push) c2m_wptr <= c2m_wptr + 1'b1;
      if (c2m_pop)  c2m_rptr <= c2m_rptr + 1'b1;
      if (c2m_push && !c2m_pop)      c2m_count <= c2m_count + 1'b1;
      else if (!c2m_push && c2m_pop) c2m_count <= c2m_count - 1'b1;
    end
  end

  // A new error event wins over a simultaneous W1C so it is never lost.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (udf_clr) udf <= 1'b0;
    end
  end

  assign m2c_cnt8 = 8'(m2c_count);
  assign c2m_cnt8 = 8'(c2m_count);
  assign status_word = {8'h00, m2c_cnt8, c2m_cnt8, 2'b00, udf, ovf,
                        c2m_full, m2c_empty, m2c_full, ~c2m_empty};

`ifdef MBOX_IRQ_EN
  logic [2:0] ctrl;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= 3'b000;
    end else if (wr_lane0 && (off == OFF_CTRL)) begin
      ctrl <= wbs_dat_i[2:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (ctrl[0] & ~c2m_empty) | (ctrl[1] & m2c_empty) | (ctrl[2] & (ovf | udf));
    end
  end

  assign ctrl_word = {29'd0, ctrl};
`else
  assign irq       = 1'b0;
  assign ctrl_word = 32'd0;
`endif

  always_comb begin
    rd_data = 32'd0;
    unique case (off)
      OFF_DATA:   rd_data = c2m_empty ? 32'd0 : c2m_mem[c2m_rptr];
      OFF_STATUS: rd_data = status_word;
      OFF_CTRL:   rd_data = ctrl_word;
      default:    rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_data : 32'd0;
    end
  end

  assign sig_unused = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_mailbox_responder.sv
// Directed bench for wb_mailbox_responder: expected bus reads and core pops are queued and checked by monitors.
module tb_wb_mailbox_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] m2c_data;
  logic        m2c_valid, m2c_ready;
  logic [31:0] c2m_data;
  logic        c2m_valid, c2m_ready;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       name;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] m2c_q[$];

  always #5 clk = ~clk;

  wb_mailbox_responder dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .m2c_data (m2c_data),
    .m2c_valid(m2c_valid),
    .m2c_ready(m2c_ready),
    .c2m_data (c2m_data),
    .c2m_valid(c2m_valid),
    .c2m_ready(c2m_ready),
    .irq      (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Bus monitor: every ack consumes one queued expectation; reads compare the returned data.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (bus_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack=1 expected none (adr %08h)", adr);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        if (e.is_rd) chk(e.name, rdat, e.exp);
      end
    end
  end

  // Core-side monitor: each M2C pop must deliver the next word the bench expects.
  always @(negedge clk) begin
    if (rst_n && m2c_valid && m2c_ready) begin
      if (m2c_q.size() == 0) chk("m2c_unexpected_pop", m2c_data, 32'hxxxx_xxxx);
      else chk("m2c_pop", m2c_data, m2c_q.pop_front());
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name);
    bus_exp_t e;
    bit       got;
    e.is_rd = ~w;
    e.exp   = exp;
    e.name  = name;
    bus_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", name);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, a, 32'd0, 4'hF, exp, name);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_xfer(1'b1, a, d, s, 32'd0, "write");
  endtask

  task automatic core_push(input logic [31:0] d);
    c2m_valid = 1'b1;
    c2m_data  = d;
    @(posedge clk); #1;
    c2m_valid = 1'b0;
  endtask

  task automatic core_pop();
    m2c_ready = 1'b1;
    @(posedge clk); #1;
    m2c_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nm_acks;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; wdat = 32'd0; m2c_ready = 1'b0; c2m_data = 32'd0; c2m_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_c2m_ready", {31'd0, c2m_ready}, 32'd1);
    chk("rst_m2c_valid", {31'd0, m2c_valid}, 32'd0);
    wb_read(BASE + 4, 32'h0000_0004, "status_after_reset");

    // Non-matching address just past the window must never be acked.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    nm_acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) nm_acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("nomatch_acks", 32'(nm_acks), 32'd0);

    // M2C basic path
    m2c_q.push_back(32'hDEAD_BEEF);
    wb_write(BASE, 32'hDEAD_BEEF, 4'hF);
    m2c_q.push_back(32'h1234_5678);
    wb_write(BASE, 32'h1234_5678, 4'hF);
    wb_write(BASE, 32'hFFFF_FFFF, 4'h0);
    chk("m2c_valid_2", {31'd0, m2c_valid}, 32'd1);
    chk("m2c_head_1", m2c_data, 32'hDEAD_BEEF);
    wb_read(BASE + 4, 32'h0002_0000, "status_m2c2");
    core_pop();
    chk("m2c_head_2", m2c_data, 32'h1234_5678);
    core_pop();
    chk("m2c_empty", {31'd0, m2c_valid}, 32'd0);

    // C2M fill to full, drain, underflow, W1C
    for (int i = 1; i <= 5; i++) begin
      core_push(32'(i) * 32'h11);
      if (i == 4) chk("c2m_ready_full", {31'd0, c2m_ready}, 32'd0);
    end
    wb_read(BASE + 4, 32'h0000_040D, "status_c2m_full");
    for (int i = 1; i <= 4; i++) wb_read(BASE, 32'(i) * 32'h11, "c2m_read");
    wb_read(BASE, 32'h0000_0000, "c2m_underflow_read");
    wb_read(BASE + 4, 32'h0000_0024, "status_udf");
    wb_write(BASE + 4, 32'h0000_0020, 4'h1);
    wb_read(BASE + 4, 32'h0000_0004, "status_udf_cleared");

    // M2C overflow then pointer wrap
    for (int i = 0; i < 5; i++) begin
      if (i < 4) m2c_q.push_back(32'hA0 + 32'(i));
      wb_write(BASE, 32'hA0 + 32'(i), 4'hF);
    end
    wb_read(BASE + 4, 32'h0004_0012, "status_ovf");
    for (int r = 0; r < 3; r++) begin
      core_pop();
      m2c_q.push_back(32'hB0 + 32'(r));
      wb_write(BASE, 32'hB0 + 32'(r), 4'hF);
    end
    wb_read(BASE + 4, 32'h0004_0012, "status_wrap_full");
    repeat (4) core_pop();
    wb_write(BASE + 4, 32'h0000_0010, 4'h1);
    wb_read(BASE + 4, 32'h0000_0004, "status_ovf_cleared");
    wb_read(BASE + 12, 32'h0000_0000, "reserved_read");

    // Simultaneous C2M push and bus pop
    core_push(32'h77);
    fork
      wb_read(BASE, 32'h77, "c2m_simul_read");
      core_push(32'h88);
    join
    wb_read(BASE + 4, 32'h0000_0105, "status_simul");
    wb_read(BASE, 32'h88, "c2m_read_after_simul");

`ifdef MBOX_IRQ_EN
    wb_write(BASE + 8, 32'h0000_0001, 4'h1);
    wb_read(BASE + 8, 32'h0000_0001, "ctrl_read");
    chk("irq_idle", {31'd0, irq}, 32'd0);
    core_push(32'h99);
    chk("irq_first_edge", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_second_edge", {31'd0, irq}, 32'd1);
    wb_read(BASE, 32'h99, "irq_drain_read");
    @(posedge clk); #1;
    chk("irq_fall", {31'd0, irq}, 32'd0);
`else
    wb_write(BASE + 8, 32'h0000_0007, 4'hF);
    wb_read(BASE + 8, 32'h0000_0000, "ctrl_read_disabled");
    core_push(32'h99);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    wb_read(BASE, 32'h99, "drain_read");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("m2c_q_drained", 32'(m2c_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
